fifo_sample_assembler: RTL
==========================

Name: fifo_sample_assembler

Overview:
- Read-side consumer of the byte-wide async FIFO in the filter input path.
- Pops bytes from the FIFO read port, packs BYTES_PER_SAMPLE consecutive bytes into one filter sample, and presents it to the transposed FIR with a valid/ready handshake.
- Runs entirely in the FIFO read clock domain. Supports resync (drop a partial sample) and counts dropped bytes.

Parameters:
- BYTE_W, 8, FIFO word width in bits.
- BYTES_PER_SAMPLE, 2, bytes per output sample (>=2).
- MSB_FIRST, 1, 1: first popped byte lands in the sample MSBs; 0: first byte lands in the LSBs.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- i_clk  in  1  read-domain clock, same clock as the FIFO read side.
- i_rst  in  1  synchronous, active-high reset.
- i_fifo_empty  in  1  FIFO read-side empty flag.
- i_fifo_data  in  BYTE_W  FIFO read data; valid combinationally whenever i_fifo_empty=0.
- o_fifo_rd_inc  out  1  pop strobe to the FIFO read increment; one byte per high cycle.
- i_resync  in  1  discard any partially assembled sample.
- o_sample  out  BYTE_W*BYTES_PER_SAMPLE  assembled sample.
- o_sample_valid  out  1  o_sample holds an unconsumed sample.
- i_sample_ready  in  1  FIR accepts o_sample this cycle when o_sample_valid=1.
- o_drop_cnt  out  CNT_W  saturating count of bytes discarded by resync.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - o_sample_valid=0, o_sample=0, o_drop_cnt=0, byte index idx=0, state=FILL.
  - o_fifo_rd_inc is forced 0 while i_rst=1.
- Accept: acc = o_sample_valid & i_sample_ready.
- Slot free: slot_free = ~o_sample_valid | acc.
- State FILL (idx = 0..BYTES_PER_SAMPLE-1):
  - o_fifo_rd_inc = ~i_fifo_empty & ~i_resync & ~i_rst (combinational).
  - Non-final pop (idx < BYTES_PER_SAMPLE-1): i_fifo_data is written into assembly slot idx; idx increments.
  - Final pop (idx = BYTES_PER_SAMPLE-1), slot_free=1: the full sample (stored bytes plus the current byte) loads into o_sample; o_sample_valid=1 next cycle; idx=0; stay in FILL.
  - Final pop, slot_free=0: the byte is stored; go to FULL.
- State FULL:
  - o_fifo_rd_inc=0.
  - When slot_free=1: the assembly register loads into o_sample, o_sample_valid=1, idx=0, go to FILL.
  - The next byte may be popped on the following cycle.
- Byte placement:
  - MSB_FIRST=1: byte k occupies bits [W-1-k*BYTE_W -: BYTE_W].
  - MSB_FIRST=0: byte k occupies bits [k*BYTE_W +: BYTE_W].
  - Samples are raw bit packing; no sign or arithmetic processing.
- Output register:
  - acc with no new load: o_sample_valid goes to 0 next cycle; o_sample holds its last value.
  - acc together with a load: o_sample_valid stays 1 and o_sample takes the new value (back-to-back samples).
  - o_sample must not change while o_sample_valid=1 and i_sample_ready=0.
- Latency and throughput:
  - The final byte's pop cycle is followed by o_sample_valid=1 at the next edge.
  - Sustained throughput is one sample per BYTES_PER_SAMPLE cycles when the FIFO stays non-empty and ready=1.
- Empty FIFO: no pop; idx holds; a partial sample is retained indefinitely.
- i_resync:
  - Has priority over any pop in the same cycle (no pop that cycle).
  - In FILL: o_drop_cnt += idx (saturating at 2^CNT_W-1); idx=0.
  - In FULL: o_drop_cnt += BYTES_PER_SAMPLE (saturating); go to FILL with idx=0.
  - The output register is untouched, so a pending valid sample survives resync.
- Reset asserted mid-assembly drops the partial sample without counting it.

Decomposition:
- Shared filter package holds:
  - state encoding (FILL, FULL);
  - SAMPLE_W = BYTE_W*BYTES_PER_SAMPLE;
  - IDX_W = $clog2(BYTES_PER_SAMPLE+1).
- One natural sub-module: sample_out_reg, the valid/ready output holding register with its load/accept logic.
- Packing, the state machine and the drop counter stay in the top module.

Test Plan:
- Bytes 0x12, 0x34 present, ready=1, MSB_FIRST=1:
  - two pops on consecutive cycles;
  - o_sample=0x1234 with valid one cycle after the second pop;
  - valid drops after one cycle.
- Same bytes with MSB_FIRST=0 -> o_sample=0x3412.
- FIFO holds 0xAA, 0xBB, 0xCC, 0xDD, 0xEE, 0xFF; ready=0 throughout:
  - 0xAABB is held stable on o_sample;
  - FULL is reached after 0xCC, 0xDD are popped, then rd_inc=0;
  - ready=1 for one cycle -> 0xCCDD next, then 0xEEFF follows in order.
- Pop 0x55, then assert i_resync -> o_drop_cnt=1, idx=0; next bytes 0x01, 0x02 -> 0x0102.
- Resync in FULL with a pending valid sample:
  - pending sample is preserved;
  - o_drop_cnt increases by 2.
- Apply 300 resyncs each with one partial byte (CNT_W=8) -> o_drop_cnt saturates at 255.
- Assert i_rst mid-sample and mid-hold:
  - all outputs 0 next cycle;
  - o_fifo_rd_inc=0 while i_rst=1.

Source files
------------

// File: rtl/fifo_sample_assembler_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sample_assembler_pkg
// Shared definitions for the FIFO sample assembler:
//   - state_t       : assembler state encoding (FILL, FULL)
//   - sample_width  : width of one assembled sample in bits
//   - idx_width     : width of the byte index, wide enough to hold
//                     BYTES_PER_SAMPLE itself (used as a drop-count increment)
// -----------------------------------------------------------------------------
package fifo_sample_assembler_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    function automatic int sample_width(input int byte_w, input int bytes_per_sample);
        return byte_w * bytes_per_sample;
    endfunction

    function automatic int idx_width(input int bytes_per_sample);
        return $clog2(bytes_per_sample + 1);
    endfunction

endpackage

// File: rtl/fifo_sample_assembler_sample_out_reg.sv
// -----------------------------------------------------------------------------
// sample_out_reg
// Valid/ready holding register for assembled samples.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            load i_load_data this cycle (only issued when slot free)
//   i_load_data       sample to load
//   i_ready           downstream accepts o_data when o_valid=1
//   o_data, o_valid   held sample and its valid flag
//   o_slot_free       register is empty or is being emptied this cycle
// -----------------------------------------------------------------------------
module sample_out_reg #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_slot_free
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         acc;

    always_comb begin
        acc         = valid_q & i_ready;
        o_slot_free = ~valid_q | acc;
        valid_d     = valid_q;
        data_d      = data_q;
        if (i_load) begin
            // A load coinciding with an accept keeps valid high (back-to-back).
            valid_d = 1'b1;
            data_d  = i_load_data;
        end else if (acc) begin
            // Data is left in place; only the valid flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/fifo_sample_assembler.sv
// -----------------------------------------------------------------------------
// fifo_sample_assembler
// Pops bytes from the read side of the input async FIFO, packs
// BYTES_PER_SAMPLE consecutive bytes into one sample and hands it to the
// FIR over a valid/ready handshake. Supports resync (drop partial sample)
// with a saturating count of discarded bytes.
// Ports:
//   i_clk, i_rst            FIFO read clock, synchronous active-high reset
//   i_fifo_empty            FIFO empty flag
//   i_fifo_data             FIFO read data (valid while not empty)
//   o_fifo_rd_inc           pop strobe, one byte per high cycle
//   i_resync                discard the partially assembled sample
//   o_sample                assembled sample
//   o_sample_valid          o_sample holds an unconsumed sample
//   i_sample_ready          downstream accepts o_sample
//   o_drop_cnt              saturating count of bytes discarded by resync
// -----------------------------------------------------------------------------
module fifo_sample_assembler
    import fifo_sample_assembler_pkg::*;
#(
    parameter int BYTE_W           = 8,
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int MSB_FIRST        = 1,
    parameter int CNT_W            = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_fifo_empty,
    input  logic [BYTE_W-1:0]                    i_fifo_data,
    output logic                                 o_fifo_rd_inc,
    input  logic                                 i_resync,
    output logic [BYTE_W*BYTES_PER_SAMPLE-1:0]   o_sample,
    output logic                                 o_sample_valid,
    input  logic                                 i_sample_ready,
    output logic [CNT_W-1:0]                     o_drop_cnt
);

    localparam int SAMPLE_W = sample_width(BYTE_W, BYTES_PER_SAMPLE);
    localparam int IDX_W    = idx_width(BYTES_PER_SAMPLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(BYTES_PER_SAMPLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [BYTE_W-1:0]   asm_q [BYTES_PER_SAMPLE];
    logic [BYTE_W-1:0]   asm_d [BYTES_PER_SAMPLE];

    logic                pop;
    logic                load;
    logic                slot_free;
    logic [IDX_W-1:0]    resync_add;
    logic [CNT_W:0]      drop_sum;
    logic [SAMPLE_W-1:0] packed_sample;

    // Assembly slots including the byte popped this cycle, so the final pop
    // can load the complete sample without an extra cycle.
    always_comb begin
        pop = (state_q == ST_FILL) & ~i_fifo_empty & ~i_resync & ~i_rst;
        for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
            asm_d[k] = asm_q[k];
            if (pop && (idx_q == IDX_W'(k))) begin
                asm_d[k] = i_fifo_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BYTES_PER_SAMPLE; gi++) begin : g_pack
            if (MSB_FIRST != 0) begin : g_msb
                assign packed_sample[SAMPLE_W-1-gi*BYTE_W -: BYTE_W] = asm_d[gi];
            end else begin : g_lsb
                assign packed_sample[gi*BYTE_W +: BYTE_W] = asm_d[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drop_cnt_d = drop_cnt_q;
        load       = 1'b0;

        // A held complete sample counts as BYTES_PER_SAMPLE dropped bytes.
        resync_add = (state_q == ST_FULL) ? IDX_FULL : idx_q;
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(resync_add);

        if (i_resync) begin
            drop_cnt_d = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
            idx_d      = '0;
            state_d    = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (pop) begin
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + 1'b1;
                        end else if (slot_free) begin
                            load  = 1'b1;
                            idx_d = '0;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (slot_free) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            drop_cnt_q <= '0;
            for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
                asm_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
                asm_q[k] <= asm_d[k];
            end
        end
    end

    sample_out_reg #(
        .W (SAMPLE_W)
    ) u_out_reg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_load_data (packed_sample),
        .i_ready     (i_sample_ready),
        .o_data      (o_sample),
        .o_valid     (o_sample_valid),
        .o_slot_free (slot_free)
    );

    assign o_fifo_rd_inc = pop;
    assign o_drop_cnt    = drop_cnt_q;

endmodule
